gpio_clk_gen: RTL and testbench

Parametrised multi-channel clock generator for the GPIO peripheral, successor to the single-channel 50%-duty toggle divider. Each channel produces a divided clock with independent period and high time, plus single-cycle rise/fall strobes for synchronous logic. Configuration changes are double-buffered and applied only at period boundaries, so outputs never glitch. A global sync input phase-aligns all running channels.

---
 rtl/gpio_clk_gen.sv | 103 ++++++++++
 tb/tb_gpio_clk_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_clk_gen.sv
// gpio_clk_gen: multi-channel programmable clock divider.
// Each channel divides clk by (P+1) with H high cycles per period and emits
// one-cycle rise/fall strobes. New period/high values are captured into a
// shadow register on load and only become active at a period boundary, when
// the channel is disabled, or on a sync/start restart, so div_clk never glitches.
//
// Handshake note: load and sync are plain one-cycle pulses with no ready path;
// pending tells software that a captured configuration is still waiting.
module gpio_clk_gen #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic [CHANNELS*WIDTH-1:0] high,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       div_clk,
  output logic [CHANNELS-1:0]       rise_stb,
  output logic [CHANNELS-1:0]       fall_stb,
  output logic [CHANNELS-1:0]       pending
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cnt, p_a, h_a, p_s, h_s;
    logic [WIDTH-1:0] cnt_n, p_a_n, h_a_n, p_s_n, h_s_n;
    logic             run, pend_q, div_q, rise_q, fall_q;
    logic             pend_n, div_n, wrap, restart, apply;

    // Next-state: boundary detection, config application, counter and output.
    always_comb begin
      // run is the registered enable; a 0->1 edge starts a fresh period.
      wrap    = run & en[c] & (cnt == p_a);
      restart = en[c] & (~run | sync | wrap);
      apply   = ~en[c] | restart;
      p_s_n   = p_s;
      h_s_n   = h_s;
      p_a_n   = p_a;
      h_a_n   = h_a;
      pend_n  = pend_q;
      if (load[c]) begin
        p_s_n = period[c*WIDTH +: WIDTH];
        h_s_n = high[c*WIDTH +: WIDTH];
        if (apply) begin
          // Capture and application coincide: use the port values directly.
          p_a_n  = period[c*WIDTH +: WIDTH];
          h_a_n  = high[c*WIDTH +: WIDTH];
          pend_n = 1'b0;
        end else begin
          pend_n = 1'b1;
        end
      end else if (apply && pend_q) begin
        p_a_n  = p_s;
        h_a_n  = h_s;
        pend_n = 1'b0;
      end
      if (!en[c] || restart) begin
        cnt_n = '0;
      end else begin
        cnt_n = cnt + ONE;
      end
      // div_clk tracks the counter it is registered alongside.
      div_n = en[c] & (cnt_n < h_a_n);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        p_a    <= '0;
        h_a    <= '0;
        p_s    <= '0;
        h_s    <= '0;
        run    <= 1'b0;
        pend_q <= 1'b0;
        div_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt    <= cnt_n;
        p_a    <= p_a_n;
        h_a    <= h_a_n;
        p_s    <= p_s_n;
        h_s    <= h_s_n;
        run    <= en[c];
        pend_q <= pend_n;
        div_q  <= div_n;
        rise_q <= div_n & ~div_q;
        fall_q <= ~div_n & div_q;
      end
    end

    assign div_clk[c]  = div_q;
    assign rise_stb[c] = rise_q;
    assign fall_stb[c] = fall_q;
    assign pending[c]  = pend_q;
  end

endmodule

// File: tb/tb_gpio_clk_gen.sv
// tb_gpio_clk_gen: directed scenarios plus randomized traffic for gpio_clk_gen,
// checked every cycle against a phase-origin reference model.
module tb_gpio_clk_gen;
  localparam int W  = 4;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   en = '0;
  logic [CH-1:0]   load = '0;
  logic [CH*W-1:0] period = '0;
  logic [CH*W-1:0] high = '0;
  logic            sync = 1'b0;
  logic [CH-1:0]   div_clk, rise_stb, fall_stb, pending;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel remembers the cycle at which its current
  // period began (origin); phase is simply now - origin.
  int            n = 0;
  int            m_org [CH];
  int            m_pa [CH], m_ha [CH], m_ps [CH], m_hs [CH];
  bit            m_pend [CH], m_run [CH];
  logic [CH-1:0] e_div, e_rise, e_fall, e_pend;

  gpio_clk_gen #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .period(period),
    .high(high), .sync(sync), .div_clk(div_clk), .rise_stb(rise_stb),
    .fall_stb(fall_stb), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_org[c] = 0; m_pa[c] = 0; m_ha[c] = 0; m_ps[c] = 0; m_hs[c] = 0;
      m_pend[c] = 0; m_run[c] = 0;
    end
    e_div = '0; e_rise = '0; e_fall = '0; e_pend = '0;
  endtask

  task automatic model_edge();
    n++;
    for (int c = 0; c < CH; c++) begin
      int  old_ph;
      int  lp, lh;
      bit  end_p, rs, ap, nd;
      old_ph = (n - 1) - m_org[c];
      end_p  = m_run[c] && en[c] && (old_ph == m_pa[c]);
      rs     = en[c] && (!m_run[c] || sync || end_p);
      ap     = !en[c] || rs;
      lp     = int'(period[c*W +: W]);
      lh     = int'(high[c*W +: W]);
      if (load[c]) begin
        m_ps[c] = lp; m_hs[c] = lh;
        if (ap) begin m_pa[c] = lp; m_ha[c] = lh; m_pend[c] = 0; end
        else m_pend[c] = 1;
      end else if (ap && m_pend[c]) begin
        m_pa[c] = m_ps[c]; m_ha[c] = m_hs[c]; m_pend[c] = 0;
      end
      if (rs) m_org[c] = n;
      m_run[c] = en[c];
      nd = en[c] && ((n - m_org[c]) < m_ha[c]);
      e_rise[c] = nd && !e_div[c];
      e_fall[c] = !nd && e_div[c];
      e_div[c]  = nd;
      e_pend[c] = m_pend[c];
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    checks++;
    if (div_clk !== e_div) begin errors++; $display("FAIL div_clk t=%0t got %b exp %b", $time, div_clk, e_div); end
    checks++;
    if (rise_stb !== e_rise) begin errors++; $display("FAIL rise_stb t=%0t got %b exp %b", $time, rise_stb, e_rise); end
    checks++;
    if (fall_stb !== e_fall) begin errors++; $display("FAIL fall_stb t=%0t got %b exp %b", $time, fall_stb, e_fall); end
    checks++;
    if (pending !== e_pend) begin errors++; $display("FAIL pending t=%0t got %b exp %b", $time, pending, e_pend); end
  endtask

  task automatic set_cfg(input int c, input int p, input int h);
    period[c*W +: W] = W'(p);
    high[c*W +: W]   = W'(h);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; load = '0; sync = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({div_clk, rise_stb, fall_stb, pending} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {div_clk, rise_stb, fall_stb, pending});
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_basic();
    bit exp_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int rises = 0;
    set_cfg(0, 3, 2); load[0] = 1'b1; en[0] = 1'b1;
    step(); load[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      checks++;
      if (div_clk[0] !== exp_pat[k % 4]) begin
        errors++; $display("FAIL basic_pattern k=%0d got %b exp %b", k, div_clk[0], exp_pat[k % 4]);
      end
      if (rise_stb[0]) rises++;
    end
    checks++;
    if (rises != 3) begin errors++; $display("FAIL basic_rises got %0d exp 3", rises); end
    en[0] = 1'b0; step(); step();
  endtask

  task automatic test_reload();
    int pend_cycles = 0;
    int highs = 0;
    bit found = 0;
    set_cfg(1, 9, 5); load[1] = 1'b1; en[1] = 1'b1;
    step(); load[1] = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if ((n - m_org[1]) == 2) found = 1; else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reload_wait got timeout exp phase 2"); end
    set_cfg(1, 3, 1); load[1] = 1'b1;
    step(); load[1] = 1'b0;
    for (int k = 0; k < 20 && pending[1]; k++) begin
      pend_cycles++; step();
    end
    checks++;
    if (pend_cycles != 7) begin errors++; $display("FAIL reload_pending got %0d exp 7", pend_cycles); end
    for (int k = 0; k < 4; k++) begin
      if (div_clk[1]) highs++;
      if (k < 3) step();
    end
    checks++;
    if (highs != 1) begin errors++; $display("FAIL reload_new_high got %0d exp 1", highs); end
    en[1] = 1'b0; step(); step();
  endtask

  task automatic test_duty();
    int strobes = 0;
    set_cfg(2, 5, 0); set_cfg(3, 5, 6); set_cfg(0, 0, 1);
    load = 4'b1101; en = 4'b1101;
    step(); load = '0;
    for (int k = 0; k < 14; k++) begin
      step();
      strobes += $countones({rise_stb[3:2], fall_stb[3:2], rise_stb[0], fall_stb[0]});
      checks++;
      if (div_clk !== 4'b1001) begin errors++; $display("FAIL duty_levels got %b exp 1001", div_clk); end
    end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL duty_strobes got %0d exp 0", strobes); end
    en = '0; step(); step();
  endtask

  task automatic test_sync();
    set_cfg(0, 7, 4); set_cfg(1, 7, 4);
    load[0] = 1'b1; en[0] = 1'b1; step(); load[0] = 1'b0;
    step(); step();
    load[1] = 1'b1; en[1] = 1'b1; step(); load[1] = 1'b0;
    step(); step(); step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (div_clk[2:0] !== {1'b0, {2{((k % 8) < 4) ? 1'b1 : 1'b0}}}) begin
        errors++; $display("FAIL sync_lock k=%0d got %b exp %b", k, div_clk[2:0], {1'b0, {2{((k % 8) < 4) ? 1'b1 : 1'b0}}});
      end
      step();
    end
    en = '0; step(); step();
  endtask

  task automatic test_legacy();
    int m = 2;
    int highs = 0;
    set_cfg(2, 2 * m + 1, m + 1); load[2] = 1'b1; en[2] = 1'b1;
    step(); load[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (div_clk[2]) highs++;
      if (k < 5) step();
    end
    checks++;
    if (highs != 3) begin errors++; $display("FAIL legacy_high got %0d exp 3", highs); end
    step();
    checks++;
    if (rise_stb[2] !== 1'b1) begin errors++; $display("FAIL legacy_period got %b exp 1", rise_stb[2]); end
    en = '0; step(); step();
  endtask

  task automatic test_wide();
    int highs = 0;
    set_cfg(3, 15, 8); load[3] = 1'b1; en[3] = 1'b1;
    step(); load[3] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (div_clk[3]) highs++;
      step();
    end
    checks++;
    if (highs != 8 || rise_stb[3] !== 1'b1) begin
      errors++; $display("FAIL wide_period got highs=%0d rise=%b exp 8/1", highs, rise_stb[3]);
    end
    set_cfg(3, 5, 2); load[3] = 1'b1; step(); load[3] = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({div_clk, rise_stb, fall_stb, pending} !== '0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {div_clk, rise_stb, fall_stb, pending});
    end
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
    set_cfg(3, 15, 8); load[3] = 1'b1; step(); load[3] = 1'b0;
    for (int k = 0; k < 20; k++) step();
    en = '0; step(); step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
        load[c] = ($urandom_range(0, 9) == 0);
        if (load[c]) set_cfg(c, $urandom_range(0, 15), $urandom_range(0, 16));
      end
      sync = ($urandom_range(0, 29) == 0);
      step();
    end
    load = '0; sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_duty();
    test_sync();
    test_legacy();
    test_wide();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
